// File: rtl/fft_result_serializer_pkg.sv
// Shared constants and types for the FFT result serializer.
package fft_result_serializer_pkg;

  localparam int DATA_W_DEF = 32;   // width of each raw butterfly output word
  localparam int OUT_W_DEF  = 16;   // width of each emitted word
  localparam int FFT_N      = 8;    // points per frame
  localparam int IDX_W      = 3;    // bin index width
  localparam int SHIFT_Q    = 8;    // Q8 twiddle scale removed on output

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  localparam logic FUN_ENABLE  = 1'b1;
  localparam logic FUN_DISABLE = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/fft_result_serializer_if.sv
// Valid/ready sample stream carrying one complex bin per beat.
interface fft_result_serializer_if #(parameter int OUT_W = 16);
  import fft_result_serializer_pkg::*;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_real;
  logic signed [OUT_W-1:0] out_imag;
  logic [IDX_W-1:0]        out_index;
  logic                    out_last;
  logic                    out_sat;

  modport master (
    output out_valid, out_real, out_imag, out_index, out_last, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_real, out_imag, out_index, out_last, out_sat,
    output out_ready
  );

endinterface

// File: rtl/fft_round_sat.sv
// Removes the fixed-point scale with round-half-up, then clips to OUT_W.
module fft_round_sat #(
  parameter int DATA_W = 32,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 16
) (
  input  logic signed [DATA_W-1:0] x,
  output logic signed [OUT_W-1:0]  y,
  output logic                     sat
);

  // One guard bit so adding the half-LSB can never wrap.
  localparam int EXT_W = DATA_W + 1;
  localparam logic signed [EXT_W-1:0] HALF  = {{(EXT_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] r;

  // Round, arithmetic-shift and clamp to the output range.
  always_comb begin
    sum = $signed({x[DATA_W-1], x}) + HALF;
    r   = sum >>> SHIFT;
    if (r > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (r < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end else begin
      y   = r[OUT_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/fft_result_serializer.sv
// Captures an 8-point FFT frame and streams it out one rounded bin per beat.
module fft_result_serializer
  import fft_result_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = SHIFT_Q,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     butterfly3_ready,
  input  logic signed [DATA_W-1:0] fft_d1_real, fft_d1_imag,
  input  logic signed [DATA_W-1:0] fft_d2_real, fft_d2_imag,
  input  logic signed [DATA_W-1:0] fft_d3_real, fft_d3_imag,
  input  logic signed [DATA_W-1:0] fft_d4_real, fft_d4_imag,
  input  logic signed [DATA_W-1:0] fft_d5_real, fft_d5_imag,
  input  logic signed [DATA_W-1:0] fft_d6_real, fft_d6_imag,
  input  logic signed [DATA_W-1:0] fft_d7_real, fft_d7_imag,
  input  logic signed [DATA_W-1:0] fft_d8_real, fft_d8_imag,
  output logic                     busy,
  output logic                     overflow,
  input  logic                     ovf_clr,
  fft_result_serializer_if.master  out_if
);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic signed [DATA_W-1:0] frame_re [FFT_N];
  logic signed [DATA_W-1:0] frame_im [FFT_N];
  logic signed [DATA_W-1:0] in_re    [FFT_N];
  logic signed [DATA_W-1:0] in_im    [FFT_N];
  logic                    accept, last_accept, capture, drop;
  logic                    valid, sat_re, sat_im;

  // Gather the incoming words into indexable form.
  always_comb begin
    in_re[0] = fft_d1_real; in_im[0] = fft_d1_imag;
    in_re[1] = fft_d2_real; in_im[1] = fft_d2_imag;
    in_re[2] = fft_d3_real; in_im[2] = fft_d3_imag;
    in_re[3] = fft_d4_real; in_im[3] = fft_d4_imag;
    in_re[4] = fft_d5_real; in_im[4] = fft_d5_imag;
    in_re[5] = fft_d6_real; in_im[5] = fft_d6_imag;
    in_re[6] = fft_d7_real; in_im[6] = fft_d7_imag;
    in_re[7] = fft_d8_real; in_im[7] = fft_d8_imag;
  end

  // Handshake events: a pulse is taken when idle or exactly as beat 7 leaves, otherwise dropped.
  always_comb begin
    accept      = (state == ST_STREAM) & out_if.out_ready;
    last_accept = accept & (idx == LAST_IDX);
    capture     = butterfly3_ready & ((state == ST_IDLE) | last_accept);
    drop        = butterfly3_ready & (state == ST_STREAM) & ~last_accept;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (butterfly3_ready) state_nxt = ST_STREAM;
                 else                  state_nxt = ST_IDLE;
      ST_STREAM: if (last_accept && !butterfly3_ready) state_nxt = ST_IDLE;
                 else                                  state_nxt = ST_STREAM;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and beat decoration.
  always_comb begin
    valid = FUN_DISABLE;
    busy  = FUN_DISABLE;
    case (state)
      ST_STREAM: begin
        valid = FUN_ENABLE;
        busy  = FUN_ENABLE;
      end
      default: begin
        valid = FUN_DISABLE;
        busy  = FUN_DISABLE;
      end
    endcase
    out_if.out_valid = valid;
    out_if.out_index = idx;
    out_if.out_last  = valid & (idx == LAST_IDX);
    out_if.out_sat   = valid & (sat_re | sat_im);
  end

  // Bin index: restarts on capture, advances on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       idx <= '0;
    else if (capture) idx <= '0;
    else if (accept)  idx <= idx + 3'd1;
  end

  // Raw frame storage, written only when a pulse is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FFT_N; k++) begin
        frame_re[k] <= '0;
        frame_im[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < FFT_N; k++) begin
        frame_re[k] <= in_re[k];
        frame_im[k] <= in_im[k];
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  fft_round_sat #(.DATA_W(DATA_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_re (
    .x   (frame_re[idx]),
    .y   (out_if.out_real),
    .sat (sat_re)
  );

  fft_round_sat #(.DATA_W(DATA_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_im (
    .x   (frame_im[idx]),
    .y   (out_if.out_imag),
    .sat (sat_im)
  );

endmodule
